// File: rtl/cwt_pkg.sv
// Shared definitions for the CWT scale scheduler.
// Holds the default frame geometry (N samples, J1 scales), the multiplier
// latency, the derived address widths and the scheduler FSM state type.
package cwt_pkg;

  localparam int unsigned N       = 256;
  localparam int unsigned J1      = 4;
  localparam int unsigned MUL_LAT = 3;

  localparam int unsigned KW = $clog2(N);       // FFT buffer address width
  localparam int unsigned SW = $clog2(J1);      // scale index width
  localparam int unsigned CW = $clog2(N * J1);  // coefficient address width

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_e;

endpackage

// File: rtl/cwt_scale_sched_if.sv
// Handshake and address bus of the CWT scale scheduler.
//   start_i, dl_busy_i, ds_ready_i : control in (master drives)
//   buf_raddr_o, coef_addr_o, scale_o : addresses out (slave drives)
//   mul_en_o, out_valid_o, out_last_o : multiplier strobes out
//   busy_o, done_o, err_o : status out
interface cwt_scale_sched_if
  import cwt_pkg::*;
#(
  parameter int unsigned N  = cwt_pkg::N,
  parameter int unsigned J1 = cwt_pkg::J1
);

  localparam int unsigned KW = $clog2(N);
  localparam int unsigned SW = (J1 > 1) ? $clog2(J1) : 1;
  localparam int unsigned CW = $clog2(N * J1);

  logic          start_i;
  logic          dl_busy_i;
  logic          ds_ready_i;
  logic [KW-1:0] buf_raddr_o;
  logic [CW-1:0] coef_addr_o;
  logic [SW-1:0] scale_o;
  logic          mul_en_o;
  logic          out_valid_o;
  logic          out_last_o;
  logic          busy_o;
  logic          done_o;
  logic          err_o;

  modport master (
    output start_i, dl_busy_i, ds_ready_i,
    input  buf_raddr_o, coef_addr_o, scale_o, mul_en_o, out_valid_o, out_last_o,
    input  busy_o, done_o, err_o
  );

  modport slave (
    input  start_i, dl_busy_i, ds_ready_i,
    output buf_raddr_o, coef_addr_o, scale_o, mul_en_o, out_valid_o, out_last_o,
    output busy_o, done_o, err_o
  );

endinterface

// File: rtl/pipe_dly.sv
// Fixed-depth delay line with asynchronous active-low reset.
//   clk, rstn : clock / reset
//   d_i       : WIDTH-bit input, advanced every cycle
//   q_o       : d_i delayed by exactly DEPTH cycles (DEPTH >= 1)
module pipe_dly #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/cwt_scale_sched.sv
// CWT scale scheduler: after an FFT frame completes, issues N*J1 multiplies
// in scale-major order (k fastest), stalling on downstream back-pressure,
// then drains the multiplier pipeline and pulses done.
//   clk, rstn : clock / asynchronous active-low reset
//   bus       : slave side of cwt_scale_sched_if (control in, addresses,
//               multiplier strobes and status out)
module cwt_scale_sched
  import cwt_pkg::*;
#(
  parameter int unsigned N       = cwt_pkg::N,
  parameter int unsigned J1      = cwt_pkg::J1,
  parameter int unsigned MUL_LAT = cwt_pkg::MUL_LAT
) (
  input logic              clk,
  input logic              rstn,
  cwt_scale_sched_if.slave bus
);

  localparam int unsigned KW = $clog2(N);
  localparam int unsigned SW = (J1 > 1) ? $clog2(J1) : 1;
  localparam int unsigned CW = $clog2(N * J1);
  localparam int unsigned DW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  localparam logic [KW-1:0] KLast = KW'(N - 1);
  localparam logic [SW-1:0] SLast = SW'(J1 - 1);
  localparam logic [DW-1:0] DLast = DW'(MUL_LAT - 1);

  state_e        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [SW-1:0] s_q, s_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          err_q;
  logic          stall, issue, k_last;

  assign stall  = bus.dl_busy_i | ~bus.ds_ready_i;
  assign issue  = (state_q == StRun) & ~stall;
  assign k_last = (k_q == KLast);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    s_d     = s_q;
    dcnt_d  = dcnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start_i) begin
          state_d = StRun;
          k_d     = '0;
          s_d     = '0;
          dcnt_d  = '0;
        end
      end
      StRun: begin
        if (issue) begin
          if (!k_last) begin
            k_d = k_q + 1'b1;
          end else begin
            k_d = '0;
            if (s_q == SLast) begin
              s_d     = '0;
              dcnt_d  = '0;
              state_d = StDrain;
            end else begin
              s_d = s_q + 1'b1;
            end
          end
        end
      end
      // Drain length is fixed: stalls do not hold the multiplier pipeline.
      StDrain: begin
        if (dcnt_q == DLast) state_d = StDone;
        else                 dcnt_d  = dcnt_q + 1'b1;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      k_q     <= '0;
      s_q     <= '0;
      dcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      s_q     <= s_d;
      dcnt_q  <= dcnt_d;
      // A start outside IDLE (including the DONE cycle) is dropped, not queued.
      err_q   <= bus.start_i & (state_q != StIdle);
    end
  end

  pipe_dly #(
    .WIDTH (2),
    .DEPTH (MUL_LAT)
  ) u_dly (
    .clk  (clk),
    .rstn (rstn),
    .d_i  ({issue, issue & k_last}),
    .q_o  ({bus.out_valid_o, bus.out_last_o})
  );

  assign bus.buf_raddr_o = k_q;
  assign bus.scale_o     = s_q;
  assign bus.coef_addr_o = CW'(32'(s_q) * N + 32'(k_q));
  assign bus.mul_en_o    = issue;
  assign bus.busy_o      = (state_q != StIdle);
  assign bus.done_o      = (state_q == StDone);
  assign bus.err_o       = err_q;

endmodule

// File: tb/tb_cwt_scale_sched.sv
// Bench for cwt_scale_sched (N=8, J1=2, MUL_LAT=3): a frame-level reference
// model checked every cycle, a table of directed frame scenarios, a reset
// abort sequence and randomly stalled frames.
module tb_cwt_scale_sched;

  localparam int unsigned N       = 8;
  localparam int unsigned J1      = 2;
  localparam int unsigned MUL_LAT = 3;
  localparam int unsigned FRAME   = N * J1;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  cwt_scale_sched_if #(.N(N), .J1(J1)) sif ();

  cwt_scale_sched #(
    .N       (N),
    .J1      (J1),
    .MUL_LAT (MUL_LAT)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (sif)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic cmp(input string name, input int act, input int want);
    n_vec++;
    if (act != want) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, want, $time);
    end
  endtask

  // Reference model: a frame is FRAME issues numbered 0..FRAME-1; the
  // multiplier outputs are the issue history seen MUL_LAT cycles later.
  int m_phase;  // 0 idle, 1 issuing, 2 draining, 3 done
  int m_idx;    // issues completed in the current frame
  int m_drain;
  bit m_err;
  bit m_v[$];
  bit m_l[$];

  function automatic void model_reset();
    m_phase = 0;
    m_idx   = 0;
    m_drain = 0;
    m_err   = 1'b0;
    m_v.delete();
    m_l.delete();
    for (int i = 0; i < MUL_LAT; i++) begin
      m_v.push_back(1'b0);
      m_l.push_back(1'b0);
    end
  endfunction

  function automatic bit m_issue();
    return (m_phase == 1) && !(sif.dl_busy_i || !sif.ds_ready_i);
  endfunction

  task automatic model_step();
    bit iss, lst;
    if (!rstn) begin
      model_reset();
      return;
    end
    iss = m_issue();
    lst = iss && ((m_idx % N) == N - 1);
    m_v.push_back(iss);
    m_l.push_back(lst);
    void'(m_v.pop_front());
    void'(m_l.pop_front());
    m_err = sif.start_i && (m_phase != 0);
    case (m_phase)
      0: if (sif.start_i) begin
        m_phase = 1;
        m_idx   = 0;
      end
      1: if (iss) begin
        m_idx++;
        if (m_idx == FRAME) begin
          m_phase = 2;
          m_idx   = 0;
          m_drain = 0;
        end
      end
      2: begin
        m_drain++;
        if (m_drain == MUL_LAT) m_phase = 3;
      end
      default: m_phase = 0;
    endcase
  endtask

  task automatic check_outputs();
    cmp("mul_en",    sif.mul_en_o,    m_issue());
    cmp("buf_raddr", sif.buf_raddr_o, m_idx % N);
    cmp("scale",     sif.scale_o,     m_idx / N);
    cmp("coef_addr", sif.coef_addr_o, m_idx);
    cmp("out_valid", sif.out_valid_o, m_v[0]);
    cmp("out_last",  sif.out_last_o,  m_l[0]);
    cmp("busy",      sif.busy_o,      m_phase != 0);
    cmp("done",      sif.done_o,      m_phase == 3);
    cmp("err",       sif.err_o,       m_err);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rstn);
      model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check_outputs();
    end
  end

  // Directed frame scenarios; cycle n is the cycle ending at edge t0+n.
  typedef struct {
    int busy_from;   // dl_busy_i high in cycles [busy_from, busy_from+busy_len)
    int busy_len;
    bit toggle_rdy;  // ds_ready_i high only in odd cycles
    int start2_at;   // stray start_i cycle, 0 = none
    int exp_done;
    int exp_first_v;
    int exp_last_v;
    int exp_nv;
    int exp_err_at;  // -1 = no err_o
    int exp_hold_k;  // k during the busy window, -1 = not checked
  } vec_t;

  task automatic run_frame(input vec_t v, input int id);
    int done_at, n_done, first_v, last_v, nv, nl, err_at, next_coef;
    bit busy_low_after;
    bit in_busy;
    done_at = -1; n_done = 0; first_v = -1; last_v = -1;
    nv = 0; nl = 0; err_at = -1; next_coef = 0; busy_low_after = 1'b0;
    @(posedge clk);
    #1;
    sif.start_i    = 1'b1;
    sif.dl_busy_i  = 1'b0;
    sif.ds_ready_i = 1'b1;
    @(posedge clk);  // t0
    for (int n = 1; n <= 60; n++) begin
      #1;
      in_busy        = (n >= v.busy_from) && (n < v.busy_from + v.busy_len);
      sif.start_i    = (n == v.start2_at);
      sif.dl_busy_i  = in_busy;
      sif.ds_ready_i = v.toggle_rdy ? ((n % 2) == 1) : 1'b1;
      @(negedge clk);
      if (sif.done_o) begin
        n_done++;
        done_at = n;
      end
      if (done_at >= 0 && n == done_at + 1) busy_low_after = !sif.busy_o;
      if (sif.out_valid_o) begin
        nv++;
        if (first_v < 0) first_v = n;
        last_v = n;
      end
      if (sif.out_last_o) nl++;
      if (sif.err_o) err_at = n;
      if (sif.mul_en_o) begin
        cmp($sformatf("s%0d seq coef", id), sif.coef_addr_o, next_coef);
        next_coef++;
      end
      if (in_busy && v.exp_hold_k >= 0) begin
        cmp($sformatf("s%0d hold k", id), sif.buf_raddr_o, v.exp_hold_k);
        cmp($sformatf("s%0d stalled mul_en", id), sif.mul_en_o, 0);
      end
      @(posedge clk);
    end
    #1;
    sif.start_i    = 1'b0;
    sif.dl_busy_i  = 1'b0;
    sif.ds_ready_i = 1'b1;
    cmp($sformatf("s%0d done cycle", id),   done_at, v.exp_done);
    cmp($sformatf("s%0d done count", id),   n_done, 1);
    cmp($sformatf("s%0d first valid", id),  first_v, v.exp_first_v);
    cmp($sformatf("s%0d last valid", id),   last_v, v.exp_last_v);
    cmp($sformatf("s%0d valid count", id),  nv, v.exp_nv);
    cmp($sformatf("s%0d last count", id),   nl, J1);
    cmp($sformatf("s%0d err cycle", id),    err_at, v.exp_err_at);
    cmp($sformatf("s%0d issue count", id),  next_coef, FRAME);
    cmp($sformatf("s%0d idle after", id),   busy_low_after, 1);
  endtask

  vec_t tbl [7];

  initial begin
    int cnt_v, cnt_d, cyc;
    bit seen;
    sif.start_i    = 1'b0;
    sif.dl_busy_i  = 1'b0;
    sif.ds_ready_i = 1'b1;
    rstn           = 1'b0;
    #2;
    cmp("reset busy",   sif.busy_o, 0);
    cmp("reset mul_en", sif.mul_en_o, 0);
    cmp("reset coef",   sif.coef_addr_o, 0);
    cmp("reset valid",  sif.out_valid_o, 0);
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;

    //           busy  len tog st2 done fv  lv  nv  err hold
    tbl[0] = '{0,   0, 1'b0, 0, 20, 4, 19, 16, -1, -1};  // clean
    tbl[1] = '{6,   5, 1'b0, 0, 25, 4, 24, 16, -1,  5};  // dl_busy stall
    tbl[2] = '{0,   0, 1'b1, 0, 35, 4, 34, 16, -1, -1};  // ds_ready toggling
    tbl[3] = '{0,   0, 1'b0, 10, 20, 4, 19, 16, 11, -1}; // start during RUN
    tbl[4] = '{17,  3, 1'b0, 0, 20, 4, 19, 16, -1, -1};  // busy through DRAIN
    tbl[5] = '{0,   0, 1'b0, 18, 20, 4, 19, 16, 19, -1}; // start during DRAIN
    tbl[6] = '{0,   0, 1'b0, 20, 20, 4, 19, 16, 21, -1}; // start during DONE
    for (int i = 0; i < 7; i++) run_frame(tbl[i], i);

    // Reset in the middle of a frame.
    @(posedge clk);
    #1;
    sif.start_i = 1'b1;
    @(posedge clk);  // t0
    #1;
    sif.start_i = 1'b0;
    repeat (8) @(posedge clk);  // edge t0+8
    #1;
    rstn = 1'b0;
    #1;
    cmp("abort mul_en", sif.mul_en_o, 0);
    cmp("abort valid",  sif.out_valid_o, 0);
    cmp("abort busy",   sif.busy_o, 0);
    cmp("abort coef",   sif.coef_addr_o, 0);
    cmp("abort raddr",  sif.buf_raddr_o, 0);
    @(posedge clk);
    #1;
    rstn  = 1'b1;
    cnt_v = 0;
    cnt_d = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (sif.out_valid_o) cnt_v++;
      if (sif.done_o) cnt_d++;
    end
    cmp("abort late valid", cnt_v, 0);
    cmp("abort late done",  cnt_d, 0);
    run_frame(tbl[0], 7);

    // Randomly stalled frames with stray starts.
    for (int f = 0; f < 8; f++) begin
      seen = 1'b0;
      cyc  = 0;
      @(posedge clk);
      #1;
      sif.start_i = 1'b1;
      @(posedge clk);
      while (!seen && cyc < 500) begin
        #1;
        sif.dl_busy_i  = ($urandom_range(0, 3) == 0);
        sif.ds_ready_i = ($urandom_range(0, 3) != 0);
        sif.start_i    = sif.busy_o && ($urandom_range(0, 19) == 0);
        @(negedge clk);
        if (sif.done_o) seen = 1'b1;
        cyc++;
        @(posedge clk);
      end
      #1;
      sif.start_i    = 1'b0;
      sif.dl_busy_i  = 1'b0;
      sif.ds_ready_i = 1'b1;
      cmp($sformatf("rand frame %0d done", f), seen, 1);
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
